// File: rtl/alu_addsub_pipe.sv
// Pipelined add/subtract ALU with valid/ready handshaking, signed/unsigned flags
// and optional saturation. Depth is 1 or 2 register stages.
module alu_addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             op,
   input  logic             Sign,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Z,
   output logic             V,
   output logic             N
);

   // Returns {V, N}: V is overflow (signed) or carry/borrow (unsigned), N is the true sign.
   function automatic logic [1:0] f_flags(input logic [WIDTH:0] raw, input logic a_msb,
                                          input logic b_msb, input logic is_sub,
                                          input logic is_signed);
      logic v;
      v = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
      if (is_signed)
         return {v, raw[WIDTH-1] ^ v};
      else
         return {is_sub ^ raw[WIDTH], is_sub & ~raw[WIDTH]};
   endfunction

   function automatic logic [WIDTH-1:0] f_saturate(input logic [WIDTH:0] raw, input logic v,
                                                   input logic n, input logic is_sub,
                                                   input logic is_signed, input logic sat_en);
      logic [WIDTH-1:0] res;
      res = raw[WIDTH-1:0];
      if (sat_en && v) begin
         if (is_signed)
            res = n ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         else
            res = is_sub ? '0 : '1;
      end
      return res;
   endfunction

   // Stage 0: combinational sum, subtract done as A + ~B + 1 for both signednesses
   logic [WIDTH-1:0] w_beff;
   logic [WIDTH:0]   w_raw_p0;
   logic             w_out_load;

   assign w_beff     = op ? ~B : B;
   assign w_raw_p0   = {1'b0, A} + {1'b0, w_beff} + {{WIDTH{1'b0}}, op};
   assign w_out_load = !out_valid || out_ready;

   logic             w_f_valid;
   logic [WIDTH:0]   w_f_raw;
   logic             w_f_amsb;
   logic             w_f_bmsb;
   logic             w_f_op;
   logic             w_f_sign;
   logic             w_f_sat;

   if (STAGES == 2) begin : g_two
      logic           r_vld_p1;
      logic [WIDTH:0] r_raw_p1;
      logic           r_amsb_p1;
      logic           r_bmsb_p1;
      logic           r_op_p1;
      logic           r_sign_p1;
      logic           r_sat_p1;
      logic           w_s1_open;

      // Stage 1 may refill in the same cycle it hands its entry to the output stage.
      assign w_s1_open = !r_vld_p1 || w_out_load;
      assign in_ready  = reset && w_s1_open;

      // Stage 1: operands' sign bits, controls and raw sum
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            r_vld_p1 <= 1'b0;
         else if (w_s1_open)
            r_vld_p1 <= in_valid;
      end

      always_ff @(posedge clk) begin
         if (in_valid && w_s1_open) begin
            r_raw_p1  <= w_raw_p0;
            r_amsb_p1 <= A[WIDTH-1];
            r_bmsb_p1 <= w_beff[WIDTH-1];
            r_op_p1   <= op;
            r_sign_p1 <= Sign;
            r_sat_p1  <= sat;
         end
      end

      assign w_f_valid = r_vld_p1;
      assign w_f_raw   = r_raw_p1;
      assign w_f_amsb  = r_amsb_p1;
      assign w_f_bmsb  = r_bmsb_p1;
      assign w_f_op    = r_op_p1;
      assign w_f_sign  = r_sign_p1;
      assign w_f_sat   = r_sat_p1;
   end else begin : g_one
      assign in_ready  = reset && w_out_load;
      assign w_f_valid = in_valid && w_out_load;
      assign w_f_raw   = w_raw_p0;
      assign w_f_amsb  = A[WIDTH-1];
      assign w_f_bmsb  = w_beff[WIDTH-1];
      assign w_f_op    = op;
      assign w_f_sign  = Sign;
      assign w_f_sat   = sat;
   end

   logic [1:0]       w_flags;
   logic [WIDTH-1:0] w_res;

   assign w_flags = f_flags(w_f_raw, w_f_amsb, w_f_bmsb, w_f_op, w_f_sign);
   assign w_res   = f_saturate(w_f_raw, w_flags[1], w_flags[0], w_f_op, w_f_sign, w_f_sat);

   // Output stage: final Result and flags, held while the consumer stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         Result    <= '0;
         Z         <= 1'b0;
         V         <= 1'b0;
         N         <= 1'b0;
      end else if (w_out_load) begin
         out_valid <= w_f_valid;
         if (w_f_valid) begin
            Result <= w_res;
            Z      <= (w_res == '0);
            V      <= w_flags[1];
            N      <= w_flags[0];
         end
      end
   end

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Bench for alu_addsub_pipe (WIDTH=32, STAGES=2): vector table, scoreboard,
// stall/backpressure sequence and mid-flight reset.
module tb_alu_addsub_pipe;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         op = 1'b0;
   logic         Sign = 1'b0;
   logic         sat = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] Result;
   logic         Z;
   logic         V;
   logic         N;

   alu_addsub_pipe #(.WIDTH(W), .STAGES(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .Sign(Sign), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Z(Z), .V(V), .N(N)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         op;
      logic         sg;
      logic         st;
      logic [W-1:0] res;
      logic         z;
      logic         v;
      logic         n;
   } vec_t;

   vec_t         sb[$];
   vec_t         cur_exp;
   vec_t         tbl[15];
   int           checks = 0;
   int           errors = 0;
   logic         prev_stall = 1'b0;
   logic [35:0]  held = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                               input logic s, input logic t, input logic [W-1:0] res,
                               input logic z, input logic v, input logic n);
      vec_t r;
      r.a = a; r.b = b; r.op = o; r.sg = s; r.st = t;
      r.res = res; r.z = z; r.v = v; r.n = n;
      return r;
   endfunction

   // Reference from exact integer arithmetic on 64-bit values.
   function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                                  input logic s, input logic t);
      vec_t   r;
      longint m;
      logic [W-1:0] wrap;
      r.a = a; r.b = b; r.op = o; r.sg = s; r.st = t;
      if (s) begin
         m = o ? (longint'($signed(a)) - longint'($signed(b)))
               : (longint'($signed(a)) + longint'($signed(b)));
         r.v = (m > 64'sd2147483647) || (m < -64'sd2147483648);
      end else begin
         m = o ? (longint'({32'd0, a}) - longint'({32'd0, b}))
               : (longint'({32'd0, a}) + longint'({32'd0, b}));
         r.v = (m < 0) || (m > 64'sd4294967295);
      end
      r.n  = (m < 0);
      wrap = m[W-1:0];
      if (t && r.v)
         r.res = s ? (r.n ? 32'h8000_0000 : 32'h7FFF_FFFF) : (r.n ? 32'h0 : 32'hFFFF_FFFF);
      else
         r.res = wrap;
      r.z = (r.res == '0);
      return r;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Monitor/scoreboard: everything sampled on the falling edge.
   initial forever begin
      vec_t e;
      @(negedge clk);
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         chk("in_ready_rule", in_ready, !(sb.size() >= 2 && !out_ready));
         if (prev_stall)
            chk("stall_hold", {out_valid, Z, V, N, Result}, held);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_out", out_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("result", Result, e.res);
               chk("flags_zvn", {Z, V, N}, {e.z, e.v, e.n});
            end
         end
         prev_stall = out_valid && !out_ready;
         held = {out_valid, Z, V, N, Result};
         if (in_valid && in_ready)
            sb.push_back(cur_exp);
      end
   end

   task automatic send(input vec_t v);
      bit acc = 1'b0;
      A = v.a; B = v.b; op = v.op; Sign = v.sg; sat = v.st;
      cur_exp = v;
      in_valid = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      // Scramble inputs so a design that fails to capture per request is exposed.
      A = $urandom; B = $urandom;
      op = 1'($urandom_range(1)); Sign = 1'($urandom_range(1)); sat = 1'($urandom_range(1));
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
      chk("drain_empty", 64'(sb.size()), 64'd0);
      #1;
   endtask

   task automatic latency(input vec_t v);
      A = v.a; B = v.b; op = v.op; Sign = v.sg; sat = v.st;
      cur_exp = v;
      in_valid = 1'b1;
      @(negedge clk);
      chk("lat_accept", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_out_valid", out_valid, 1'b0);
      @(negedge clk);
      chk("lat_cycle2_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = mk(32'h3,         32'h5,         1, 1, 0, 32'hFFFF_FFFE, 0, 0, 1);
      tbl[1]  = mk(32'h7FFF_FFFF, 32'h1,         0, 1, 0, 32'h8000_0000, 0, 1, 0);
      tbl[2]  = mk(32'h7FFF_FFFF, 32'h1,         0, 1, 1, 32'h7FFF_FFFF, 0, 1, 0);
      tbl[3]  = mk(32'hFFFF_FFFF, 32'h1,         0, 0, 0, 32'h0,         1, 1, 0);
      tbl[4]  = mk(32'h3,         32'h5,         1, 0, 1, 32'h0,         1, 1, 1);
      tbl[5]  = mk(32'h3,         32'h5,         1, 0, 0, 32'hFFFF_FFFE, 0, 1, 1);
      tbl[6]  = mk(32'h8000_0000, 32'h1,         1, 1, 1, 32'h8000_0000, 0, 1, 1);
      tbl[7]  = mk(32'h8000_0000, 32'h1,         1, 1, 0, 32'h7FFF_FFFF, 0, 1, 1);
      tbl[8]  = mk(32'h5,         32'h5,         1, 1, 0, 32'h0,         1, 0, 0);
      tbl[9]  = mk(32'h5,         32'h5,         1, 0, 0, 32'h0,         1, 0, 0);
      tbl[10] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFF, 0, 1, 0);
      tbl[11] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 1);
      tbl[12] = mk(32'h0,         32'h0,         0, 0, 0, 32'h0,         1, 0, 0);
      tbl[13] = mk(32'h8000_0000, 32'h8000_0000, 0, 1, 1, 32'h8000_0000, 0, 1, 1);
      tbl[14] = mk(32'h1234_5678, 32'h1111_1111, 0, 0, 0, 32'h2345_6789, 0, 0, 0);

      #2 reset = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", Result, 32'h0);
      chk("rst_zvn", {Z, V, N}, 3'b000);
      chk("rst_in_ready", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1 chk("in_ready_after_release", in_ready, 1'b1);
      @(posedge clk);
      #1;

      latency(tbl[0]);
      drain();

      for (int i = 0; i < 15; i++) send(tbl[i]);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++)
               send(model(pick(), pick(), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1))));
         end
         begin
            for (int c = 0; c < 60; c++) begin
               @(posedge clk);
               #1;
               out_ready = (c % 3 == 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      out_ready = 1'b0;
      send(tbl[1]);
      send(tbl[3]);
      #2 reset = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_result", Result, 32'h0);
      chk("midrst_zvn", {Z, V, N}, 3'b000);
      chk("midrst_in_ready", in_ready, 1'b0);
      sb.delete();
      @(posedge clk);
      #3 reset = 1'b1;
      out_ready = 1'b1;
      #1 chk("midrst_in_ready_release", in_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_stale_out_valid", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      latency(tbl[2]);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_addsub_pipe.md
ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter: STAGES, 2, pipeline depth in cycles (legal values 1 or 2).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  operation request.
REQ-006 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port: A  input  WIDTH  first operand.
REQ-008 SHALL have port: B  input  WIDTH  second operand.
REQ-009 SHALL have port: op  input  1  0 = add, 1 = subtract (A-B).
REQ-010 SHALL have port: Sign  input  1  1 = signed (two's complement), 0 = unsigned.
REQ-011 SHALL have port: sat  input  1  1 = saturate on overflow, 0 = wrap.
REQ-012 SHALL have port: out_valid  output  1  result presented.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port: Result  output  WIDTH  final result.
REQ-015 SHALL have port: Z  output  1  Result equals zero.
REQ-016 SHALL have port: V  output  1  overflow (signed) or carry/borrow (unsigned).
REQ-017 SHALL have port: N  output  1  true sign of mathematical result.

Function
REQ-018 SHALL accept a request when in_valid && in_ready; SHALL transfer a result when out_valid && out_ready.
REQ-019 SHALL present each accepted request at outputs exactly STAGES cycles after acceptance if never stalled.
REQ-020 SHALL hold stage k when stage k is valid and stage k+1 (or output) is valid and not advancing; in_ready = !s1_valid || s1 advancing (same-cycle accept while draining permitted).
REQ-021 SHALL keep Result, Z, V, N, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL sustain one transfer per cycle with out_ready held high; no bubbles, no drops, no duplicates, order preserved.
REQ-023 SHALL compute raw = A + (op ? ~B : B) + op at WIDTH+1 bits for both Sign values (unsigned subtract uses two's complement too).
REQ-024 Unsigned: V SHALL equal raw[WIDTH] for add and ~raw[WIDTH] for subtract; N SHALL be 1 only for unsigned subtract with borrow.
REQ-025 Signed: V SHALL equal (A[msb] == Beff[msb]) && (raw[msb] != A[msb]), Beff = op ? ~B : B; N SHALL equal raw[msb] ^ V.
REQ-026 sat=0: Result SHALL equal raw[WIDTH-1:0].
REQ-027 sat=1 and V=1: Result SHALL be signed max if N=0, signed min if N=1; unsigned all-ones for add, zero for subtract.
REQ-028 Z SHALL be computed on final (post-saturation) Result; V and N SHALL report the pre-saturation condition.
REQ-029 op, Sign, sat SHALL be captured per request with operands; changing them while stalled SHALL not affect in-flight entries.
REQ-030 STAGES=2: stage 1 registers operands/controls and raw sum; stage 2 registers Result and flags. STAGES=1: single register stage holding Result and flags.

Reset
REQ-031 reset low SHALL immediately clear all stage valids, out_valid=0, Result=0, Z=0, V=0, N=0, regardless of clk.
REQ-032 in_ready SHALL be 0 while reset is low and 1 in the first cycle after release.
REQ-033 Requests in flight at reset assertion SHALL be discarded; no result emitted for them after release.

Verification
REQ-034 WIDTH=32, STAGES=2, out_ready=1: A=3, B=5, op=1, Sign=1, sat=0 -> 2 cycles later Result=0xFFFFFFFE, N=1, V=0, Z=0.
REQ-035 Signed add 0x7FFFFFFF+1: sat=0 -> Result=0x80000000, V=1, N=0; sat=1 -> Result=0x7FFFFFFF, V=1, Z=0.
REQ-036 Unsigned: 0xFFFFFFFF+1 sat=0 -> Result=0, Z=1, V=1, N=0; 3-5 sat=1 -> Result=0, V=1, N=1, Z=1.
REQ-037 Back-to-back 8 requests, out_ready toggled 1,0,0,1,...: all 8 results in order, outputs stable during stalls, in_ready low only when both stages full and stalled.
REQ-038 Reset asserted mid-clock with 2 entries in flight -> outputs 0 immediately; after release no stale out_valid, next request emerges after 2 cycles.
